// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared opcodes and default widths for the reservation station
package reservation_station_pkg;

  localparam int RS_WIDTH_DEF  = 3;
  localparam int ROB_WIDTH_DEF = 4;
  localparam int XLEN          = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_BLT  = 4'd13;
  localparam logic [3:0] OP_JAL  = 4'd14;
  localparam logic [3:0] OP_JALR = 4'd15;

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - issue, result-bus snoop and ALU dispatch signals
interface reservation_station_if
  import reservation_station_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
);
  // issue from decoder / ROB
  logic                 issue_signal;
  logic [3:0]           issue_opcode;
  logic [XLEN-1:0]      issue_vj;
  logic [ROB_WIDTH-1:0] issue_qj;
  logic                 issue_qj_wait;
  logic [XLEN-1:0]      issue_vk;
  logic [ROB_WIDTH-1:0] issue_qk;
  logic                 issue_qk_wait;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 rs_full;
  // result buses
  logic                 alu_done;
  logic [XLEN-1:0]      alu_value;
  logic [ROB_WIDTH-1:0] alu_tag;
  logic                 lsb_done;
  logic [XLEN-1:0]      lsb_value;
  logic [ROB_WIDTH-1:0] lsb_tag;
  // dispatch to ALU
  logic                 cal_signal;
  logic [3:0]           opcode;
  logic [XLEN-1:0]      lhs;
  logic [XLEN-1:0]      rhs;
  logic [ROB_WIDTH-1:0] tag;

  modport master (
    output issue_signal, issue_opcode, issue_vj, issue_qj, issue_qj_wait,
           issue_vk, issue_qk, issue_qk_wait, issue_tag,
           alu_done, alu_value, alu_tag, lsb_done, lsb_value, lsb_tag,
    input  rs_full, cal_signal, opcode, lhs, rhs, tag
  );

  modport slave (
    input  issue_signal, issue_opcode, issue_vj, issue_qj, issue_qj_wait,
           issue_vk, issue_qk, issue_qk_wait, issue_tag,
           alu_done, alu_value, alu_tag, lsb_done, lsb_value, lsb_tag,
    output rs_full, cal_signal, opcode, lhs, rhs, tag
  );

endinterface

// File: rtl/reservation_station_pick.sv
// rtl/reservation_station_pick.sv - lowest-index priority encoder (valid + index)
module reservation_station_pick #(
  parameter int WIDTH = 3
) (
  input  logic [(1<<WIDTH)-1:0] req,
  output logic                  valid,
  output logic [WIDTH-1:0]      index
);

  // scan from the top down so the lowest set bit is the last to overwrite index
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = (1 << WIDTH) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = i[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station: hold, snoop, issue one ready entry per cycle
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_WIDTH  = RS_WIDTH_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  reservation_station_if.slave bus
);

  localparam int RS_SIZE = 1 << RS_WIDTH;

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   qj_wait;
  logic [RS_SIZE-1:0]   qk_wait;
  logic [3:0]           op   [RS_SIZE];
  logic [XLEN-1:0]      vj   [RS_SIZE];
  logic [XLEN-1:0]      vk   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk   [RS_SIZE];
  logic [ROB_WIDTH-1:0] dest [RS_SIZE];

  logic [RS_SIZE-1:0]   ready;
  logic                 free_valid;
  logic                 ready_valid;
  logic [RS_WIDTH-1:0]  free_idx;
  logic [RS_WIDTH-1:0]  ready_idx;

  logic                 new_j_wait;
  logic                 new_k_wait;
  logic [XLEN-1:0]      new_vj;
  logic [XLEN-1:0]      new_vk;

  logic                 cal_q;
  logic [3:0]           opcode_q;
  logic [XLEN-1:0]      lhs_q;
  logic [XLEN-1:0]      rhs_q;
  logic [ROB_WIDTH-1:0] tag_q;

  assign bus.rs_full    = &busy;
  assign bus.cal_signal = cal_q;
  assign bus.opcode     = opcode_q;
  assign bus.lhs        = lhs_q;
  assign bus.rhs        = rhs_q;
  assign bus.tag        = tag_q;

  // an entry is dispatchable only from registered state, never from this cycle's broadcast
  always_comb begin
    ready = busy & ~qj_wait & ~qk_wait;
  end

  reservation_station_pick #(.WIDTH(RS_WIDTH)) u_free_pick (
    .req   (~busy),
    .valid (free_valid),
    .index (free_idx)
  );

  reservation_station_pick #(.WIDTH(RS_WIDTH)) u_ready_pick (
    .req   (ready),
    .valid (ready_valid),
    .index (ready_idx)
  );

  // resolve issuing operands against the result buses of the same cycle; ALU bus wins
  always_comb begin
    new_vj     = bus.issue_vj;
    new_j_wait = bus.issue_qj_wait;
    if (bus.issue_qj_wait && bus.alu_done && bus.alu_tag == bus.issue_qj) begin
      new_vj     = bus.alu_value;
      new_j_wait = 1'b0;
    end else if (bus.issue_qj_wait && bus.lsb_done && bus.lsb_tag == bus.issue_qj) begin
      new_vj     = bus.lsb_value;
      new_j_wait = 1'b0;
    end
    new_vk     = bus.issue_vk;
    new_k_wait = bus.issue_qk_wait;
    if (bus.issue_qk_wait && bus.alu_done && bus.alu_tag == bus.issue_qk) begin
      new_vk     = bus.alu_value;
      new_k_wait = 1'b0;
    end else if (bus.issue_qk_wait && bus.lsb_done && bus.lsb_tag == bus.issue_qk) begin
      new_vk     = bus.lsb_value;
      new_k_wait = 1'b0;
    end
  end

  // entry storage: snoop, dispatch lowest ready entry, then accept a new issue into the lowest free slot
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy     <= '0;
      cal_q    <= 1'b0;
      opcode_q <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      tag_q    <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        busy  <= '0;
        cal_q <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_wait[i]) begin
            if (bus.alu_done && bus.alu_tag == qj[i]) begin
              vj[i]      <= bus.alu_value;
              qj_wait[i] <= 1'b0;
            end else if (bus.lsb_done && bus.lsb_tag == qj[i]) begin
              vj[i]      <= bus.lsb_value;
              qj_wait[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_wait[i]) begin
            if (bus.alu_done && bus.alu_tag == qk[i]) begin
              vk[i]      <= bus.alu_value;
              qk_wait[i] <= 1'b0;
            end else if (bus.lsb_done && bus.lsb_tag == qk[i]) begin
              vk[i]      <= bus.lsb_value;
              qk_wait[i] <= 1'b0;
            end
          end
        end

        if (ready_valid) begin
          cal_q           <= 1'b1;
          opcode_q        <= op[ready_idx];
          lhs_q           <= vj[ready_idx];
          rhs_q           <= vk[ready_idx];
          tag_q           <= dest[ready_idx];
          busy[ready_idx] <= 1'b0;
        end else begin
          cal_q <= 1'b0;
        end

        // free_idx comes from pre-edge busy, so it never collides with ready_idx
        if (bus.issue_signal && free_valid) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= bus.issue_opcode;
          vj[free_idx]      <= new_vj;
          vk[free_idx]      <= new_vk;
          qj[free_idx]      <= bus.issue_qj;
          qk[free_idx]      <= bus.issue_qk;
          qj_wait[free_idx] <= new_j_wait;
          qk_wait[free_idx] <= new_k_wait;
          dest[free_idx]    <= bus.issue_tag;
        end
      end
    end
  end

endmodule
